// File: rtl/decode_stage_if.sv
// Fetch/write-back/execute-facing signal bundle of the RV32I decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_in;
  logic [31:0]     instr_in;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            pc_write;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [4:0]      id_ex_rd;
  logic [6:0]      id_ex_opcode;
  logic [2:0]      id_ex_funct3;
  logic            id_ex_funct7b5;
  logic            id_ex_mem_read;

  // Fetch has no handshake: an instruction presented while pc_write=1 is taken
  // at the next rising edge; while pc_write=0 the IF/ID contents are held.
  modport slave (
    input  pc_in, instr_in, flush, wb_en, wb_rd, wb_data,
    output pc_write, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_opcode,
           id_ex_funct3, id_ex_funct7b5, id_ex_mem_read
  );

  modport master (
    output pc_in, instr_in, flush, wb_en, wb_rd, wb_data,
    input  pc_write, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_opcode,
           id_ex_funct3, id_ex_funct7b5, id_ex_mem_read
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, immediate generation,
// load-use stall detection and ID/EX register. Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.slave  bus
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [XLEN-1:0] if_id_pc_q;
  logic [31:0]     if_id_instr_q;
  logic            if_id_valid_q;
  logic [XLEN-1:0] rf_q [32];

  logic            id_ex_valid_q, id_ex_mem_read_q, id_ex_funct7b5_q;
  logic [XLEN-1:0] id_ex_pc_q, id_ex_rs1_data_q, id_ex_rs2_data_q, id_ex_imm_q;
  logic [4:0]      id_ex_rs1_q, id_ex_rs2_q, id_ex_rd_q;
  logic [6:0]      id_ex_opcode_q;
  logic [2:0]      id_ex_funct3_q;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [XLEN-1:0] imm_d, rs1_data_d, rs2_data_d;
  logic            rs1_used, rs2_used, stall;

  assign opcode   = if_id_instr_q[6:0];
  assign rd       = if_id_instr_q[11:7];
  assign funct3   = if_id_instr_q[14:12];
  assign rs1      = if_id_instr_q[19:15];
  assign rs2      = if_id_instr_q[24:20];
  assign funct7b5 = if_id_instr_q[30];

  always_comb begin
    imm_d = '0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        imm_d = {{20{if_id_instr_q[31]}}, if_id_instr_q[31:20]};
      OPC_STORE:
        imm_d = {{20{if_id_instr_q[31]}}, if_id_instr_q[31:25], if_id_instr_q[11:7]};
      OPC_BRANCH:
        imm_d = {{19{if_id_instr_q[31]}}, if_id_instr_q[31], if_id_instr_q[7],
                 if_id_instr_q[30:25], if_id_instr_q[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_d = {if_id_instr_q[31:12], 12'b0};
      OPC_JAL:
        imm_d = {{11{if_id_instr_q[31]}}, if_id_instr_q[31], if_id_instr_q[19:12],
                 if_id_instr_q[20], if_id_instr_q[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    if (rs1 != 5'd0) begin
      rs1_data_d = rf_q[rs1];
`ifdef REGFILE_BYPASS_EN
      if (bus.wb_en && (bus.wb_rd == rs1)) rs1_data_d = bus.wb_data;
`endif
    end
    if (rs2 != 5'd0) begin
      rs2_data_d = rf_q[rs2];
`ifdef REGFILE_BYPASS_EN
      if (bus.wb_en && (bus.wb_rd == rs2)) rs2_data_d = bus.wb_data;
`endif
    end
  end

  assign rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  // The bubble this inserts into ID/EX clears id_ex_mem_read, so a stall never exceeds one cycle.
  assign stall = if_id_valid_q && id_ex_valid_q && id_ex_mem_read_q && (id_ex_rd_q != 5'd0) &&
                 ((rs1_used && (rs1 == id_ex_rd_q)) || (rs2_used && (rs2 == id_ex_rd_q)));
  assign bus.pc_write = ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else if (bus.flush) begin
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else if (!stall) begin
      if_id_pc_q    <= bus.pc_in;
      if_id_instr_q <= bus.instr_in;
      if_id_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      rf_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid_q    <= 1'b0;
      id_ex_pc_q       <= '0;
      id_ex_rs1_data_q <= '0;
      id_ex_rs2_data_q <= '0;
      id_ex_imm_q      <= '0;
      id_ex_rs1_q      <= '0;
      id_ex_rs2_q      <= '0;
      id_ex_rd_q       <= '0;
      id_ex_opcode_q   <= '0;
      id_ex_funct3_q   <= '0;
      id_ex_funct7b5_q <= 1'b0;
      id_ex_mem_read_q <= 1'b0;
    end else if (bus.flush || stall) begin
      id_ex_valid_q    <= 1'b0;
      id_ex_pc_q       <= '0;
      id_ex_rs1_data_q <= '0;
      id_ex_rs2_data_q <= '0;
      id_ex_imm_q      <= '0;
      id_ex_rs1_q      <= '0;
      id_ex_rs2_q      <= '0;
      id_ex_rd_q       <= '0;
      id_ex_opcode_q   <= '0;
      id_ex_funct3_q   <= '0;
      id_ex_funct7b5_q <= 1'b0;
      id_ex_mem_read_q <= 1'b0;
    end else begin
      id_ex_valid_q    <= if_id_valid_q;
      id_ex_pc_q       <= if_id_pc_q;
      id_ex_rs1_data_q <= rs1_data_d;
      id_ex_rs2_data_q <= rs2_data_d;
      id_ex_imm_q      <= imm_d;
      id_ex_rs1_q      <= rs1;
      id_ex_rs2_q      <= rs2;
      id_ex_rd_q       <= rd;
      id_ex_opcode_q   <= opcode;
      id_ex_funct3_q   <= funct3;
      id_ex_funct7b5_q <= funct7b5;
      id_ex_mem_read_q <= (opcode == OPC_LOAD);
    end
  end

  assign bus.id_ex_valid    = id_ex_valid_q;
  assign bus.id_ex_pc       = id_ex_pc_q;
  assign bus.id_ex_rs1_data = id_ex_rs1_data_q;
  assign bus.id_ex_rs2_data = id_ex_rs2_data_q;
  assign bus.id_ex_imm      = id_ex_imm_q;
  assign bus.id_ex_rs1      = id_ex_rs1_q;
  assign bus.id_ex_rs2      = id_ex_rs2_q;
  assign bus.id_ex_rd       = id_ex_rd_q;
  assign bus.id_ex_opcode   = id_ex_opcode_q;
  assign bus.id_ex_funct3   = id_ex_funct3_q;
  assign bus.id_ex_funct7b5 = id_ex_funct7b5_q;
  assign bus.id_ex_mem_read = id_ex_mem_read_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-decoded instructions are queued as
// expected ID/EX contents and popped by a monitor whenever id_ex_valid is high.
module tb_decode_stage;
  localparam int W = 155;
`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_X5 = 32'hDEAD_BEEF;
`else
  localparam logic [31:0] BYP_X5 = 32'h0000_0000;
`endif

  logic clk;
  logic rst;
  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic [31:0] rs1d,
                                      input logic [31:0] rs2d, input logic [31:0] imm,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [6:0] opc,
                                      input logic [2:0] f3, input logic f7b5, input logic mr);
    return {pc, rs1d, rs2d, imm, rs1, rs2, rd, opc, f3, f7b5, mr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present one fetch word, wait out any stall, then let one edge take it
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic fl,
                       input logic push, input logic [W-1:0] e);
    bus.pc_in    = pc;
    bus.instr_in = instr;
    bus.flush    = fl;
    stall_cnt    = 0;
    while (!fl && bus.pc_write !== 1'b1 && stall_cnt < 4) begin
      @(posedge clk); #1;
      stall_cnt++;
      check("stall_bubble_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    end
    if (!fl && bus.pc_write !== 1'b1) check("stall_timeout_pc_write", {31'b0, bus.pc_write}, 32'd1);
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.id_ex_valid === 1'b1) begin
      mon_act = mk(bus.id_ex_pc, bus.id_ex_rs1_data, bus.id_ex_rs2_data, bus.id_ex_imm,
                   bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd, bus.id_ex_opcode,
                   bus.id_ex_funct3, bus.id_ex_funct7b5, bus.id_ex_mem_read);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_ex_unexpected: got %h expected nothing", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL id_ex_fields pc=%h: got %h expected %h", bus.id_ex_pc, mon_act, mon_exp);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst          = 1'b1;
    bus.pc_in    = '0;
    bus.instr_in = 32'h0000_0013;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    #12;
    check("rst_pc_write", {31'b0, bus.pc_write}, 32'd1);
    check("rst_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    check("rst_pc", bus.id_ex_pc, 32'd0);
    check("rst_imm", bus.id_ex_imm, 32'd0);
    check("rst_opcode", {25'b0, bus.id_ex_opcode}, 32'd0);
    check("rst_rd", {27'b0, bus.id_ex_rd}, 32'd0);
    check("rst_mem_read", {31'b0, bus.id_ex_mem_read}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // preload x7 and x8 while flushing so nothing enters the pipe
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h0000_00A5;
    drive(32'h0, 32'h0000_0013, 1'b1, 1'b0, '0);
    bus.wb_rd = 5'd8; bus.wb_data = 32'h1234_5678;
    drive(32'h0, 32'h0000_0013, 1'b1, 1'b0, '0);
    bus.wb_en = 1'b0;

    // addi x1,x0,5 then load-use lw x2 / add x3,x2,x2
    drive(32'h00, 32'h0050_0093, 1'b0, 1'b1, mk(32'h00, 0, 0, 32'h5, 0, 5, 1, 7'h13, 0, 0, 0));
    check("latency_one_edge_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    drive(32'h10, 32'h0000_A103, 1'b0, 1'b1, mk(32'h10, 0, 0, 0, 1, 0, 2, 7'h03, 2, 0, 1));
    drive(32'h14, 32'h0021_01B3, 1'b0, 1'b1, mk(32'h14, 0, 0, 0, 2, 2, 3, 7'h33, 0, 0, 0));
    drive(32'h18, 32'h0013_8213, 1'b0, 1'b1, mk(32'h18, 32'hA5, 0, 32'h1, 7, 1, 4, 7'h13, 0, 0, 0));
    check("load_use_stall_cycles", stall_cnt, 32'd1);

    // lw x2 then addi x9,x0,2: rs2 field matches but is unused, so no stall
    drive(32'h1C, 32'h0000_A103, 1'b0, 1'b1, mk(32'h1C, 0, 0, 0, 1, 0, 2, 7'h03, 2, 0, 1));
    drive(32'h20, 32'h0020_0493, 1'b0, 1'b1, mk(32'h20, 0, 0, 32'h2, 0, 2, 9, 7'h13, 0, 0, 0));
    drive(32'h24, 32'h0013_8213, 1'b0, 1'b0, '0);
    check("no_false_stall_cycles", stall_cnt, 32'd0);

    // flush squashes the instruction in IF/ID; IF/ID then holds the NOP bubble
    drive(32'h28, 32'h0000_0013, 1'b1, 1'b0, '0);
    check("flush_idex_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    check("flush_idex_rd", {27'b0, bus.id_ex_rd}, 32'd0);
    drive(32'h2C, 32'hFFF4_0513, 1'b0, 1'b1,
          mk(32'h2C, 32'h1234_5678, 0, 32'hFFFF_FFFF, 8, 31, 10, 7'h13, 0, 1, 0));
    check("bubble_after_flush_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    check("bubble_after_flush_opcode", {25'b0, bus.id_ex_opcode}, 32'h13);

    // write-back to x5 in the cycle add x6,x5,x0 is decoded; then write to x0
    drive(32'h30, 32'h0002_8333, 1'b0, 1'b1, mk(32'h30, BYP_X5, 0, 0, 5, 0, 6, 7'h33, 0, 0, 0));
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    drive(32'h34, 32'h0002_85B3, 1'b0, 1'b1, mk(32'h34, 32'hDEAD_BEEF, 0, 0, 5, 0, 11, 7'h33, 0, 0, 0));
    bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
    drive(32'h38, 32'h0000_0693, 1'b0, 1'b1, mk(32'h38, 0, 0, 0, 0, 0, 13, 7'h13, 0, 0, 0));
    bus.wb_en = 1'b0;

    // immediate formats: B, U, J, S
    drive(32'h3C, 32'hFE00_0EE3, 1'b0, 1'b1, mk(32'h3C, 0, 0, 32'hFFFF_FFFC, 0, 0, 29, 7'h63, 0, 1, 0));
    drive(32'h40, 32'h1234_50B7, 1'b0, 1'b1,
          mk(32'h40, 32'h1234_5678, 0, 32'h1234_5000, 8, 3, 1, 7'h37, 5, 0, 0));
    drive(32'h44, 32'h0080_00EF, 1'b0, 1'b1, mk(32'h44, 0, 32'h1234_5678, 32'h8, 0, 8, 1, 7'h6F, 0, 0, 0));
    drive(32'h48, 32'h0083_A223, 1'b0, 1'b1,
          mk(32'h48, 32'hA5, 32'h1234_5678, 32'h4, 7, 8, 4, 7'h23, 2, 0, 0));

    // reset asserted while a load-use stall is pending
    drive(32'h4C, 32'h0000_A103, 1'b0, 1'b1, mk(32'h4C, 0, 0, 0, 1, 0, 2, 7'h03, 2, 0, 1));
    drive(32'h50, 32'h0021_01B3, 1'b0, 1'b0, '0);
    check("pre_reset_stall_pc_write", {31'b0, bus.pc_write}, 32'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    check("async_rst_pc", bus.id_ex_pc, 32'd0);
    check("async_rst_rd", {27'b0, bus.id_ex_rd}, 32'd0);
    check("async_rst_mem_read", {31'b0, bus.id_ex_mem_read}, 32'd0);
    check("async_rst_pc_write", {31'b0, bus.pc_write}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // refill; x5 must read back as cleared
    drive(32'h100, 32'h0050_0093, 1'b0, 1'b1, mk(32'h100, 0, 0, 32'h5, 0, 5, 1, 7'h13, 0, 0, 0));
    check("refill_latency_valid", {31'b0, bus.id_ex_valid}, 32'd0);
    drive(32'h104, 32'h0000_0013, 1'b0, 1'b0, '0);
    check("refill_arrival_valid", {31'b0, bus.id_ex_valid}, 32'd1);
    drive(32'h108, 32'h0000_0013, 1'b1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
